infrared_tx: RTL
================

# infrared_tx

NEC-protocol infrared transmitter, the transmit counterpart of `infrared_rx`. It accepts a 32-bit frame word (or a repeat request) on a one-cycle start strobe. It produces the NEC mark/space envelope and the 38 kHz modulated drive for an IR LED. Intended use is board-to-board loopback testing of `infrared_rx` and remote-control emulation in the game tops.

## Interface
Parameters:
- `CLK_MHZ`, default 50: system clock frequency in MHz.
- `CARRIER_KHZ`, default 38: carrier frequency in kHz.

Ports:
- `CLK`  in  1: system clock.
- `RST_N`  in  1: asynchronous, active-low reset.
- `DATA`  in  32: frame word, latched on accepted `START`. `DATA[0]` is transmitted first. Bit order and byte layout are identical to the word `infrared_rx` reports.
- `START`  in  1: one-cycle request, accepted only while `BUSY`=0.
- `REPEAT`  in  1: sampled with `START`. 1 selects a repeat code, and `DATA` is ignored.
- `BUSY`  out  1: frame in progress.
- `DONE`  out  1: one-cycle pulse at frame end.
- `ENVELOPE`  out  1: unmodulated mark (1) / space (0).
- `IR_OUT`  out  1: modulated LED drive, equal to `ENVELOPE` AND carrier.

## Operation
- `UNIT` = `CLK_MHZ`*5625/10 cycles (562.5 µs); 28125 at 50 MHz.
- `CARR_PERIOD` = `CLK_MHZ`*1000/`CARRIER_KHZ` (1315 at defaults).
- `CARR_HIGH` = `CARR_PERIOD`/3 (438 at defaults).
- States:
  - `IDLE`
  - `LEAD_MARK` (16 units)
  - `LEAD_SPACE` (8 units)
  - `REP_SPACE` (4 units)
  - `BIT_MARK` (1 unit)
  - `BIT_SPACE` (1 unit for a 0, 3 units for a 1)
  - `STOP_MARK` (1 unit)
- Data frame path: `IDLE` → `LEAD_MARK` → `LEAD_SPACE` → (`BIT_MARK` → `BIT_SPACE`) ×32 → `STOP_MARK` → `IDLE`.
- Repeat path: `IDLE` → `LEAD_MARK` → `REP_SPACE` → `STOP_MARK` → `IDLE`.
- Counters:
  - Unit-cycle counter counts 0..`UNIT`-1.
  - Unit counter counts units within the current state.
  - 5-bit bit index runs 0..31. The shift register shifts right after each `BIT_SPACE`.
- `ENVELOPE`=1 in every `*_MARK` state, 0 otherwise.
- Carrier phase counter counts 0..`CARR_PERIOD`-1. It is forced to 0 on entry to every mark state, so each mark starts with carrier high. Carrier is high while phase < `CARR_HIGH`.
- `START` while `BUSY`=1 is ignored; `DATA` and `REPEAT` are not resampled.

## Timing
- All outputs are registered.
- Reset values: `BUSY`=0, `DONE`=0, `ENVELOPE`=0, `IR_OUT`=0, state `IDLE`, all counters 0.
- `START` accepted at edge k: `BUSY`, `ENVELOPE` and `IR_OUT` go to 1 from cycle k+1.
- Each state lasts exactly (units × `UNIT`) cycles. There are no extra transition cycles.
- Data frame length:
  - (16+8+1) units + 2 units per 0-bit + 4 units per 1-bit.
  - All-zero word: 89 units.
  - All-ones word: 153 units.
- Repeat frame length: 21 units.
- In the first `IDLE` cycle after `STOP_MARK`: `BUSY`=0, `DONE`=1, `ENVELOPE`=0.
  - A `START` in this same cycle is accepted.
  - The next frame then begins one cycle later with no dead time.
- Reset asserted mid-frame: all outputs are low immediately (asynchronous). No `DONE` is produced. After release the block is `IDLE`.
- `REPEAT` and `DATA` are don't-care except in the `START` cycle.

## Structure
- Shared package `infrared_pkg`:
  - `ir_tx_state_t` enum.
  - Unit-count constants `LEAD_MARK_U`=16, `LEAD_SPACE_U`=8, `REP_SPACE_U`=4, `BIT_MARK_U`=1, `ZERO_SPACE_U`=1, `ONE_SPACE_U`=3, `STOP_MARK_U`=1.
  - `infrared_rx` reuses these for its tolerance windows.
- One sub-module, `ir_carrier_gen`:
  - Inputs: `CLK`, `RST_N`, `SYNC` (phase reset).
  - Output: `CARRIER`.
  - Parameterised by `CARR_PERIOD` and `CARR_HIGH`.

## Test plan
All scenarios use defaults (`CLK_MHZ`=50, `UNIT`=28125).
- Reset: hold `RST_N`=0 for 10 cycles → all outputs 0. Release with no `START` for 1000 cycles → outputs remain 0.
- `DATA`=32'h0000_0001, `START` → `BUSY` high for exactly 91×28125 = 2,559,375 cycles.
  - `ENVELOPE` high 450,000 cycles, then low 225,000.
  - First bit space is 84,375 cycles; the remaining bit spaces are 28,125.
  - `DONE` pulses once.
- `REPEAT`=1, `START` → `BUSY` high for 590,625 cycles. `ENVELOPE` pattern is 450,000 high, 112,500 low, 28,125 high.
- Carrier during leader mark:
  - `IR_OUT` pulses are 438 cycles high, 877 low.
  - 343 rising edges occur within the mark; the first is in the cycle after `START`.
  - `IR_OUT`=0 throughout every space.
- `START` pulses mid-frame with a different `DATA` → ignored; the waveform is unchanged. `START` on the `DONE` cycle → next frame begins the following cycle.
- Loopback `IR_OUT` through inverter into `infrared_rx` with `DATA`=32'hF708_FB04 → rx asserts `ir_data_ready` once with `ir_data`=32'hF708_FB04 and error code 0.
- Reset asserted at cycle 600,000 of a data frame → outputs are 0 the same cycle. No `DONE`. A subsequent frame is correct.

Source files
------------

// File: rtl/infrared_pkg.sv
// Shared NEC infrared definitions: transmitter state encoding and protocol durations
// in 562.5 us units, reused by the receiver for its tolerance windows.
package infrared_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      REP_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } ir_tx_state_t;

   localparam int unsigned LEAD_MARK_U  = 16;
   localparam int unsigned LEAD_SPACE_U = 8;
   localparam int unsigned REP_SPACE_U  = 4;
   localparam int unsigned BIT_MARK_U   = 1;
   localparam int unsigned ZERO_SPACE_U = 1;
   localparam int unsigned ONE_SPACE_U  = 3;
   localparam int unsigned STOP_MARK_U  = 1;

   // Length of a state in units; a bit space depends on the bit being sent.
   function automatic logic [4:0] state_units(input ir_tx_state_t st, input logic bit_val);
      state_units = 5'd1;
      case (st)
         LEAD_MARK:  state_units = 5'(LEAD_MARK_U);
         LEAD_SPACE: state_units = 5'(LEAD_SPACE_U);
         REP_SPACE:  state_units = 5'(REP_SPACE_U);
         BIT_MARK:   state_units = 5'(BIT_MARK_U);
         BIT_SPACE:  state_units = bit_val ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
         STOP_MARK:  state_units = 5'(STOP_MARK_U);
         default:    state_units = 5'd1;
      endcase
   endfunction

   function automatic logic is_mark(input ir_tx_state_t st);
      is_mark = (st == LEAD_MARK) || (st == BIT_MARK) || (st == STOP_MARK);
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase counter. CARRIER is the level for the coming cycle so the caller can
// register it with its own next-state; SYNC makes the coming cycle phase 0 (carrier high).
module ir_carrier_gen #(
   parameter int CARR_PERIOD = 1315,
   parameter int CARR_HIGH   = 438
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic SYNC,
   output logic CARRIER
);
   localparam int PW = (CARR_PERIOD > 1) ? $clog2(CARR_PERIOD) : 1;

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;

   always_comb begin
      phase_d = phase_q + PW'(1);
      if (SYNC || (phase_q == PW'(CARR_PERIOD - 1))) begin
         phase_d = '0;
      end
      CARRIER = (phase_d < PW'(CARR_HIGH));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/infrared_tx.sv
// NEC infrared transmitter: sends a 32-bit word (LSB first) or a repeat code as a mark/space
// envelope plus carrier-modulated LED drive. Outputs registered; START taken only while idle.
module infrared_tx
   import infrared_pkg::*;
#(
   parameter int CLK_MHZ     = 50,
   parameter int CARRIER_KHZ = 38,
   parameter int UNIT        = CLK_MHZ * 5625 / 10
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] DATA,
   input  logic        START,
   input  logic        REPEAT,
   output logic        BUSY,
   output logic        DONE,
   output logic        ENVELOPE,
   output logic        IR_OUT
);
   localparam int CARR_PERIOD = CLK_MHZ * 1000 / CARRIER_KHZ;
   localparam int CARR_HIGH   = CARR_PERIOD / 3;
   localparam int CYC_W       = (UNIT > 1) ? $clog2(UNIT) : 1;

   ir_tx_state_t     state_q;
   logic [CYC_W-1:0] cyc_q;
   logic [4:0]       unit_q;
   logic [4:0]       bit_q;
   logic [31:0]      shreg_q;
   logic             rep_q;
   logic             busy_q;
   logic             done_q;
   logic             env_q;
   logic             ir_q;

   logic unit_end;
   logic state_end;
   logic mark_entry;
   logic env_d;
   logic carrier;

   // Mark entries restart the carrier so every mark begins on a high carrier cycle.
   always_comb begin
      unit_end   = (cyc_q == CYC_W'(UNIT - 1));
      state_end  = (state_q != IDLE) && unit_end &&
                   (unit_q == state_units(state_q, shreg_q[0]) - 5'd1);
      mark_entry = ((state_q == IDLE) && START) ||
                   (state_end && ((state_q == LEAD_SPACE) || (state_q == REP_SPACE) ||
                                  (state_q == BIT_SPACE)));
      env_d      = mark_entry || (is_mark(state_q) && !state_end);
   end

   ir_carrier_gen #(
      .CARR_PERIOD (CARR_PERIOD),
      .CARR_HIGH   (CARR_HIGH)
   ) u_carrier (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .SYNC    (mark_entry),
      .CARRIER (carrier)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         unit_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         rep_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         env_q   <= 1'b0;
         ir_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         env_q  <= env_d;
         ir_q   <= env_d & carrier;
         if (state_q == IDLE) begin
            cyc_q  <= '0;
            unit_q <= '0;
            if (START) begin
               state_q <= LEAD_MARK;
               shreg_q <= DATA;
               rep_q   <= REPEAT;
               bit_q   <= '0;
               busy_q  <= 1'b1;
            end
         end else if (unit_end) begin
            cyc_q  <= '0;
            unit_q <= state_end ? 5'd0 : unit_q + 5'd1;
            if (state_end) begin
               case (state_q)
                  LEAD_MARK:  state_q <= rep_q ? REP_SPACE : LEAD_SPACE;
                  LEAD_SPACE: state_q <= BIT_MARK;
                  REP_SPACE:  state_q <= STOP_MARK;
                  BIT_MARK:   state_q <= BIT_SPACE;
                  BIT_SPACE: begin
                     shreg_q <= shreg_q >> 1;
                     bit_q   <= bit_q + 5'd1;
                     state_q <= (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
                  end
                  default: begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               endcase
            end
         end else begin
            cyc_q <= cyc_q + CYC_W'(1);
         end
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ENVELOPE = env_q;
   assign IR_OUT   = ir_q;

endmodule
